// File: rtl/risc16_pkg.sv
// Shared definitions for the 16-bit RISC core boot path: the data widths and
// the instruction-memory loader state type.
package risc16_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned INSTR_W = 16;

    // ST_CHK is only reachable when the checksum option is built in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/xor_checksum.sv
// Running XOR accumulator over the loader's data bytes.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the accumulator (takes priority over en)
//   en       : fold din into the accumulator
//   din      : data byte
//   sum      : current XOR of all bytes folded in since the last clear
module xor_checksum
    import risc16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum ^ din;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles little-endian byte pairs from
// a valid/ready stream into 16-bit words and writes them to consecutive
// instruction-memory addresses from 0, holding the core stalled meanwhile.
// Optional feature: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : load request, honoured only when idle
//   word_count    : words to load (1..2^ADDR_W), sampled with start
//   s_data/s_valid/s_ready : byte stream handshake
//   imem_we/imem_addr/imem_wdata : instruction-memory write port
//   cpu_hold, busy : high while a load is in progress
//   done          : one-cycle completion pulse
//   err           : sticky error flag, cleared by the next accepted start
module imem_loader
    import risc16_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W:0]     word_count,
    input  logic [BYTE_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [INSTR_W-1:0]  imem_wdata,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(2**ADDR_W);

    loader_state_t     state;
    logic [ADDR_W-1:0] last_addr;
    logic              byte_acc;
    logic              count_ok;

    assign byte_acc = s_valid & s_ready;
    assign count_ok = (word_count != '0) && (word_count <= MAX_COUNT);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
    logic              csum_clr;
    logic              csum_en;

    assign csum_clr = (state == ST_IDLE) && start && count_ok;
    assign csum_en  = byte_acc && ((state == ST_LOW) || (state == ST_HIGH));

    xor_checksum u_xor_checksum (
        .clk (clk),
        .rst (rst),
        .clr (csum_clr),
        .en  (csum_en),
        .din (s_data),
        .sum (csum)
    );
`endif

    // Loader FSM; every output is registered alongside the state transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_addr  <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (count_ok) begin
                            state     <= ST_LOW;
                            last_addr <= ADDR_W'(word_count - (ADDR_W+1)'(1));
                            imem_addr <= '0;
                            err       <= 1'b0;
                            s_ready   <= 1'b1;
                            busy      <= 1'b1;
                            cpu_hold  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOW: begin
                    if (byte_acc) begin
                        imem_wdata[BYTE_W-1:0] <= s_data;
                        state                  <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (byte_acc) begin
                        imem_wdata[INSTR_W-1:BYTE_W] <= s_data;
                        state                        <= ST_WRITE;
                        s_ready                      <= 1'b0;
                        imem_we                      <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // Address stops at the last word; it never wraps.
                    if (imem_addr == last_addr) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state   <= ST_CHK;
                        s_ready <= 1'b1;
`else
                        state <= ST_DONE;
                        done  <= 1'b1;
`endif
                    end else begin
                        imem_addr <= imem_addr + ADDR_W'(1);
                        state     <= ST_LOW;
                        s_ready   <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (byte_acc) begin
                        if (s_data != csum) begin
                            err <= 1'b1;
                        end
                        state   <= ST_DONE;
                        s_ready <= 1'b0;
                        done    <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_W = 4).
module tb_imem_loader;

    localparam int unsigned ADDR_W = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [ADDR_W:0] word_count;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter and write/done monitors, sampled on the falling edge.
    int         cyc = 0;
    int         n_wr = 0;
    int         n_done = 0;
    int         done_cyc = 0;
    logic [3:0] wr_addr [0:63];
    logic [15:0] wr_data [0:63];
    int         wr_cyc  [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we && n_wr < 64) begin
            wr_addr[n_wr] = imem_addr;
            wr_data[n_wr] = imem_wdata;
            wr_cyc[n_wr]  = cyc;
            n_wr = n_wr + 1;
        end
        if (done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
    end

    logic [7:0] stream [0:63];
    int         slen;

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Append the XOR of the queued bytes (or a deliberately wrong one).
    task automatic append_trailer(input bit bad);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < slen; i++) x = x ^ stream[i];
        stream[slen] = bad ? ~x : x;
        slen++;
    endtask
`endif

    // Called at a falling edge; offers each byte until it is accepted.
    task automatic send_bytes(input bit gaps, input int start_at);
        int  idx;
        int  guard;
        bit  acc;
        idx   = 0;
        guard = 0;
        while (idx < slen && guard < 2000) begin
            s_valid    = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data     = stream[idx];
            start      = (idx == start_at);
            word_count = 5'd5;
            acc        = s_valid && s_ready;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (idx < slen) check("send_timeout", 32'(idx), 32'(slen));
    endtask

    task automatic wait_done(input int base);
        int guard;
        guard = 0;
        while (n_done == base && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (n_done == base) check("done_timeout", 32'(n_done), 32'(base + 1));
    endtask

    task automatic do_start(input logic [ADDR_W:0] wc);
        start      = 1'b1;
        word_count = wc;
        @(negedge clk);
        start = 1'b0;
    endtask

    int wbase;
    int dbase;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        word_count = '0;
        s_data     = '0;
        s_valid    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_s_ready",  32'(s_ready), 32'd0);
        check("rst_we",       32'(imem_we), 32'd0);
        check("rst_addr",     32'(imem_addr), 32'd0);
        check("rst_wdata",    32'(imem_wdata), 32'd0);
        check("rst_hold",     32'(cpu_hold), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_err",      32'(err), 32'd0);
        rst = 1'b0;

        // Idle with valid data but no start: nothing accepted.
        s_valid = 1'b1;
        s_data  = 8'h5A;
        repeat (5) @(negedge clk);
        check("idle_s_ready", 32'(s_ready), 32'd0);
        check("idle_writes",  32'(n_wr), 32'd0);
        check("idle_busy",    32'(busy), 32'd0);
        s_valid = 1'b0;

        // Two words, back-to-back bytes.
        wbase = n_wr;
        dbase = n_done;
        do_start(5'd2);
        check("start_hold",    32'(cpu_hold), 32'd1);
        check("start_busy",    32'(busy), 32'd1);
        check("start_s_ready", 32'(s_ready), 32'd1);
        stream[0] = 8'h34; stream[1] = 8'h12; stream[2] = 8'h78; stream[3] = 8'h56;
        slen = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
        append_trailer(1'b0);
`endif
        send_bytes(1'b0, -1);
        wait_done(dbase);
        check("w2_hold_at_done", 32'(cpu_hold), 32'd1);
        check("w2_nwr",   32'(n_wr - wbase), 32'd2);
        check("w2_addr0", 32'(wr_addr[wbase]), 32'd0);
        check("w2_data0", 32'(wr_data[wbase]), 32'h1234);
        check("w2_addr1", 32'(wr_addr[wbase+1]), 32'd1);
        check("w2_data1", 32'(wr_data[wbase+1]), 32'h5678);
        check("w2_spacing", 32'(wr_cyc[wbase+1] - wr_cyc[wbase]), 32'd3);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("w2_done_lat", 32'(done_cyc - wr_cyc[wbase+1]), 32'd1);
`endif
        check("w2_err", 32'(err), 32'd0);
        @(negedge clk);
        check("w2_hold_fall", 32'(cpu_hold), 32'd0);
        check("w2_busy_fall", 32'(busy), 32'd0);
        check("w2_done_once", 32'(n_done - dbase), 32'd1);

        // Illegal word counts.
        wbase = n_wr;
        do_start(5'd0);
        check("wc0_err",  32'(err), 32'd1);
        check("wc0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        do_start(5'd17);
        check("wc17_err",  32'(err), 32'd1);
        check("wc17_busy", 32'(busy), 32'd0);
        check("wc17_s_ready", 32'(s_ready), 32'd0);
        check("wcbad_nwr", 32'(n_wr - wbase), 32'd0);

        // Next legal start clears err.
        dbase = n_done;
        do_start(5'd1);
        check("clr_err", 32'(err), 32'd0);
        stream[0] = 8'h0D; stream[1] = 8'hF0;
        slen = 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
        append_trailer(1'b0);
`endif
        send_bytes(1'b0, -1);
        wait_done(dbase);
        check("wc1_data", 32'(wr_data[n_wr-1]), 32'hF00D);
        @(negedge clk);

        // Full 16-word load with stream gaps and ignored mid-load start.
        wbase = n_wr;
        dbase = n_done;
        do_start(5'd16);
        for (int i = 0; i < 16; i++) begin
            stream[2*i]   = 8'(i * 17);
            stream[2*i+1] = 8'(8'hC0 + i);
        end
        slen = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
        append_trailer(1'b0);
`endif
        send_bytes(1'b1, 9);
        wait_done(dbase);
        check("w16_nwr", 32'(n_wr - wbase), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("w16_addr", 32'(wr_addr[wbase+i]), 32'(i));
            check("w16_data", 32'(wr_data[wbase+i]), 32'({8'(8'hC0 + i), 8'(i * 17)}));
        end
        check("w16_err", 32'(err), 32'd0);
        @(negedge clk);
        check("w16_done_once", 32'(n_done - dbase), 32'd1);
        check("w16_idle", 32'(busy), 32'd0);

        // Reset after the first word has been written.
        wbase = n_wr;
        dbase = n_done;
        do_start(5'd3);
        stream[0] = 8'hAA; stream[1] = 8'hBB;
        slen = 2;
        send_bytes(1'b0, -1);
        @(negedge clk);
        check("rmid_nwr", 32'(n_wr - wbase), 32'd1);
        rst = 1'b1;
        #1;
        check("rmid_s_ready", 32'(s_ready), 32'd0);
        check("rmid_addr",    32'(imem_addr), 32'd0);
        check("rmid_wdata",   32'(imem_wdata), 32'd0);
        check("rmid_hold",    32'(cpu_hold), 32'd0);
        check("rmid_busy",    32'(busy), 32'd0);
        check("rmid_we",      32'(imem_we), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rmid_no_done", 32'(n_done - dbase), 32'd0);

        // Load after reset starts again from address 0.
        wbase = n_wr;
        do_start(5'd1);
        stream[0] = 8'hEF; stream[1] = 8'hBE;
        slen = 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
        append_trailer(1'b0);
`endif
        send_bytes(1'b0, -1);
        wait_done(dbase);
        check("rpost_addr", 32'(wr_addr[wbase]), 32'd0);
        check("rpost_data", 32'(wr_data[wbase]), 32'hBEEF);
        @(negedge clk);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Good and bad checksum trailers.
        dbase = n_done;
        do_start(5'd1);
        stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03;
        slen = 3;
        send_bytes(1'b0, -1);
        wait_done(dbase);
        check("csum_good_err", 32'(err), 32'd0);
        @(negedge clk);
        dbase = n_done;
        do_start(5'd1);
        stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'hFF;
        slen = 3;
        send_bytes(1'b0, -1);
        wait_done(dbase);
        check("csum_bad_done", 32'(n_done - dbase), 32'd1);
        check("csum_bad_err", 32'(err), 32'd1);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
